// File: rtl/axis_sim_pkg.sv
// Shared definitions for the simulated video-line stream: FSM encoding,
// error-code bit positions, geometry helpers and the deterministic word pattern.
package axis_sim_pkg;

    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_RECV     = 2'd1;
    localparam logic [1:0] ST_RESYNC   = 2'd2;

    localparam int ERR_DATA  = 0;
    localparam int ERR_TLAST = 1;
    localparam int ERR_STRB  = 2;
    localparam int ERR_BITS  = 3;

    function automatic int words_per_line(int pixels_h);
        return pixels_h / 4;
    endfunction

    function automatic int lines_per_frame(int pixels_v);
        return pixels_v;
    endfunction

    // Word w of line v in frame f: w + {f, v, 16'h0}, wrapping mod 2^32.
    function automatic logic [31:0] expected_word(logic [15:0] w, logic [3:0] f, logic [11:0] v);
        return {16'h0, w} + {f, v, 16'h0};
    endfunction

endpackage

// File: rtl/axis_ready_throttle.sv
// Registered TREADY driven from a free-running 3-bit phase counter and an
// 8-bit throttle mask; reusable by any stream sink.
module axis_ready_throttle #(
    parameter logic [7:0] READY_PATTERN = 8'hFF
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tready_o
);

    logic [2:0] phase_q;
    logic       tready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q  <= 3'd0;
            tready_q <= 1'b0;
        end else begin
            phase_q  <= phase_q + 3'd1;
            tready_q <= READY_PATTERN[phase_q];
        end
    end

    assign tready_o = tready_q;

endmodule

// File: rtl/saxis_frame_checker.sv
// AXI4-Stream sink that locks onto the generator's video-line pattern and
// reports data/TLAST/TSTRB errors, a saturating error total and line/frame progress.
module saxis_frame_checker
    import axis_sim_pkg::*;
#(
    parameter int         C_S_AXIS_TDATA_WIDTH = 32,
    parameter int         PIXELS_HORIZONTAL    = 1280,
    parameter int         PIXELS_VERTICAL      = 1024,
    parameter logic [7:0] READY_PATTERN        = 8'hFF
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESETN,
    input  logic                                S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,
    output logic                                locked,
    output logic                                err_data,
    output logic                                err_tlast,
    output logic                                err_strb,
    output logic                                frame_done,
    output logic [15:0]                         error_count,
    output logic [11:0]                         line_count,
    output logic [3:0]                          frame_count
);

    localparam int          W      = words_per_line(PIXELS_HORIZONTAL);
    localparam int          V      = lines_per_frame(PIXELS_VERTICAL);
    localparam logic [15:0] W_LAST = 16'(W - 1);
    localparam logic [11:0] V_LAST = 12'(V - 1);

    logic                tready;
    logic                beat;
    logic                line_end;
    logic [1:0]          state_q, state_d;
    logic [15:0]         w_q, w_d;
    logic [11:0]         v_q, v_d;
    logic [3:0]          f_q, f_d;
    logic                locked_q, locked_d;
    logic [ERR_BITS-1:0] err_q, err_d;
    logic                fdone_q, fdone_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [16:0]         cnt_sum;

    axis_ready_throttle #(
        .READY_PATTERN(READY_PATTERN)
    ) u_throttle (
        .clk_i   (S_AXIS_ACLK),
        .rst_ni  (S_AXIS_ARESETN),
        .tready_o(tready)
    );

    assign beat = S_AXIS_TVALID & tready;

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        v_d      = v_q;
        f_d      = f_q;
        locked_d = locked_q;
        err_d    = '0;
        fdone_d  = 1'b0;
        line_end = 1'b0;
        if (beat) begin
            case (state_q)
                ST_WAIT_SOF: begin
                    if (S_AXIS_TDATA[27:0] == 28'h0) begin
                        f_d      = S_AXIS_TDATA[31:28];
                        v_d      = 12'h0;
                        w_d      = 16'd1;
                        locked_d = 1'b1;
                        state_d  = ST_RECV;
                        line_end = S_AXIS_TLAST && (W == 1);
                    end
                end
                ST_RECV: begin
                    err_d[ERR_DATA] = S_AXIS_TDATA != expected_word(w_q, f_q, v_q);
                    err_d[ERR_STRB] = S_AXIS_TSTRB != '1;
                    if (S_AXIS_TLAST) begin
                        err_d[ERR_TLAST] = w_q != W_LAST;
                        line_end         = 1'b1;
                    end else if (w_q == W_LAST) begin
                        // The line's last word still closes the line, so RESYNC
                        // skips the following line and RECV resumes one after it.
                        err_d[ERR_TLAST] = 1'b1;
                        line_end         = 1'b1;
                        state_d          = ST_RESYNC;
                    end else begin
                        w_d = w_q + 16'd1;
                    end
                end
                ST_RESYNC: begin
                    if (S_AXIS_TLAST) begin
                        line_end = 1'b1;
                        state_d  = ST_RECV;
                    end
                end
                default: state_d = ST_WAIT_SOF;
            endcase
        end
        // Line-end advances from v_d so a one-word SOF line starts from v=0.
        if (line_end) begin
            w_d = 16'd0;
            if (v_d == V_LAST) begin
                v_d     = 12'h0;
                f_d     = f_d + 4'd1;
                fdone_d = 1'b1;
            end else begin
                v_d = v_d + 12'd1;
            end
        end
        cnt_sum = {1'b0, cnt_q} + 17'(err_d[ERR_DATA]) + 17'(err_d[ERR_TLAST])
                + 17'(err_d[ERR_STRB]);
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q  <= ST_WAIT_SOF;
            w_q      <= 16'd0;
            v_q      <= 12'h0;
            f_q      <= 4'h0;
            locked_q <= 1'b0;
            err_q    <= '0;
            fdone_q  <= 1'b0;
            cnt_q    <= 16'h0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            v_q      <= v_d;
            f_q      <= f_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            fdone_q  <= fdone_d;
            cnt_q    <= cnt_d;
        end
    end

    assign S_AXIS_TREADY = tready;
    assign locked        = locked_q;
    assign err_data      = err_q[ERR_DATA];
    assign err_tlast     = err_q[ERR_TLAST];
    assign err_strb      = err_q[ERR_STRB];
    assign frame_done    = fdone_q;
    assign error_count   = cnt_q;
    assign line_count    = v_q;
    assign frame_count   = f_q;

endmodule

// File: tb/tb_saxis_frame_checker.sv
// Randomised stream against a frame/line-level reference model, with
// per-cycle output comparison and hand-computed scenario end-state checks.
module tb_saxis_frame_checker;

    localparam int         H   = 16;
    localparam int         W   = H / 4;
    localparam int         V   = 3;
    localparam logic [7:0] PAT = 8'b1010_0110;

    logic        clk, rst_n;
    logic        tvalid, tlast, tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        locked, err_data, err_tlast, err_strb, frame_done;
    logic [15:0] error_count;
    logic [11:0] line_count;
    logic [3:0]  frame_count;

    saxis_frame_checker #(
        .C_S_AXIS_TDATA_WIDTH(32),
        .PIXELS_HORIZONTAL   (H),
        .PIXELS_VERTICAL     (V),
        .READY_PATTERN       (PAT)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESETN(rst_n),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .locked        (locked),
        .err_data      (err_data),
        .err_tlast     (err_tlast),
        .err_strb      (err_strb),
        .frame_done    (frame_done),
        .error_count   (error_count),
        .line_count    (line_count),
        .frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 hunting for start of frame, 1 checking words, 2 skipping to TLAST.
    int   m_mode, m_w, m_v, m_f, m_cnt, cyc;
    bit   m_locked, e_data, e_tlast, e_strb, e_fd, e_ready;
    int   pc_data, pc_tlast, pc_strb, pc_fd;
    logic [7:0] pat_v;

    function automatic void m_line_end();
        m_w = 0;
        m_v = m_v + 1;
        if (m_v == V) begin
            m_v  = 0;
            m_f  = (m_f + 1) % 16;
            e_fd = 1'b1;
        end
    endfunction

    function automatic void m_beat(logic [31:0] d, logic [3:0] s, logic l);
        logic [31:0] exp_d;
        if (m_mode == 0) begin
            if (d[27:0] == 28'h0) begin
                m_f = int'(d[31:28]); m_v = 0; m_w = 1; m_locked = 1'b1; m_mode = 1;
                if (l && W == 1) m_line_end();
            end
        end else if (m_mode == 1) begin
            exp_d  = 32'(m_w) + (32'(m_f) << 28) + (32'(m_v) << 16);
            e_data = (d != exp_d);
            e_strb = (s != 4'hF);
            if (l) begin
                e_tlast = (m_w != W - 1);
                m_line_end();
            end else if (m_w == W - 1) begin
                e_tlast = 1'b1;
                m_line_end();
                m_mode = 2;
            end else begin
                m_w = m_w + 1;
            end
        end else if (l) begin
            m_line_end();
            m_mode = 1;
        end
        m_cnt = m_cnt + int'(e_data) + int'(e_tlast) + int'(e_strb);
        if (m_cnt > 65535) m_cnt = 65535;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_w = 0; m_v = 0; m_f = 0; m_cnt = 0; cyc = 0;
            m_locked = 0; e_data = 0; e_tlast = 0; e_strb = 0; e_fd = 0; e_ready = 0;
            pc_data = 0; pc_tlast = 0; pc_strb = 0; pc_fd = 0;
        end else begin
            e_data = 0; e_tlast = 0; e_strb = 0; e_fd = 0;
            if (tvalid && tready) m_beat(tdata, tstrb, tlast);
            pat_v   = PAT;
            e_ready = pat_v[cyc % 8];
            cyc++;
            #1;
            if (rst_n) begin
                chk("cycle_outputs",
                    {tready, locked, err_data, err_tlast, err_strb, frame_done,
                     error_count, line_count, frame_count},
                    {e_ready, m_locked, e_data, e_tlast, e_strb, e_fd,
                     16'(m_cnt), 12'(m_v), 4'(m_f)});
                pc_data  += int'(err_data);
                pc_tlast += int'(err_tlast);
                pc_strb  += int'(err_strb);
                pc_fd    += int'(frame_done);
            end
        end
    end

    // Present one beat from a negedge and hold it until the sink takes it.
    task automatic put(logic [31:0] d, logic [3:0] s, logic l, bit gaps);
        bit rdy;
        bit ok;
        if (gaps) while ($urandom_range(3) == 0) begin tvalid = 1'b0; @(negedge clk); end
        tvalid = 1'b1; tdata = d; tstrb = s; tlast = l;
        ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
            rdy = tready;
            @(negedge clk);
            if (rdy) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_line(int f, int v, int nw, int bad_w, logic [31:0] x, int strb_w,
                             int early_w, bit drop_last, bit gaps);
        logic [31:0] base;
        logic [31:0] d;
        base = {4'(f), 12'(v), 16'h0};
        for (int w = 0; w < nw; w++) begin
            d = base + 32'(w);
            if (w == bad_w) d = d ^ x;
            put(d, (w == strb_w) ? 4'h7 : 4'hF,
                ((w == W - 1) && !drop_last) || (w == early_w), gaps);
            if (w == early_w) break;
        end
    endtask

    task automatic idle(int n);
        tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs",
               {tready, locked, err_data, err_tlast, err_strb, frame_done,
                error_count, line_count, frame_count}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic end_state(string name, int fc, int lc, int ec, int lk);
        chk({name, "_frame_count"}, 64'(frame_count), 64'(fc));
        chk({name, "_line_count"},  64'(line_count),  64'(lc));
        chk({name, "_error_count"}, 64'(error_count), 64'(ec));
        chk({name, "_locked"},      64'(locked),      64'(lk));
    endtask

    initial begin
        int f0, kind, fw;
        logic [31:0] x;
        rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Clean stream preceded by junk, two frames.
        put(32'h5000_0001, 4'hF, 1'b0, 1'b1);
        put(32'h0000_0103, 4'hF, 1'b1, 1'b1);
        for (int f = 0; f < 2; f++)
            for (int v = 0; v < V; v++) send_line(f, v, W, -1, 0, -1, -1, 1'b0, 1'b1);
        idle(4);
        end_state("clean", 2, 0, 0, 1);
        chk("clean_frame_done_pulses", 64'(pc_fd), 64'd2);

        // Continuously valid source, word 2 of line 1 corrupted.
        do_reset();
        for (int v = 0; v < V; v++) send_line(0, v, W, (v == 1) ? 2 : -1, 32'h1, -1, -1, 1'b0, 1'b0);
        idle(4);
        end_state("corrupt", 1, 0, 1, 1);
        chk("corrupt_err_data_pulses", 64'(pc_data), 64'd1);

        // Early TLAST at word 1 of line 0.
        do_reset();
        for (int v = 0; v < V; v++) send_line(0, v, W, -1, 0, -1, (v == 0) ? 1 : -1, 1'b0, 1'b1);
        idle(4);
        end_state("early", 1, 0, 1, 1);
        chk("early_err_tlast_pulses", 64'(pc_tlast), 64'd1);

        // Missing TLAST on line 0; line 1 is skipped, line 2 checked.
        do_reset();
        for (int v = 0; v < V; v++) send_line(0, v, W, -1, 0, -1, -1, v == 0, 1'b1);
        idle(4);
        end_state("missing", 1, 0, 1, 1);
        chk("missing_err_tlast_pulses", 64'(pc_tlast), 64'd1);

        // TSTRB fault, then reset mid-line and relock on frame 3.
        do_reset();
        send_line(2, 0, W, -1, 0, 1, -1, 1'b0, 1'b1);
        send_line(2, 1, 2, -1, 0, -1, -1, 1'b0, 1'b1);
        idle(2);
        end_state("strb", 2, 1, 1, 1);
        chk("strb_err_strb_pulses", 64'(pc_strb), 64'd1);
        do_reset();
        for (int v = 0; v < V; v++) send_line(3, v, W, -1, 0, -1, -1, 1'b0, 1'b1);
        idle(4);
        end_state("relock", 4, 0, 0, 1);

        // Random faults over several frames; the model covers every cycle.
        do_reset();
        f0 = $urandom_range(15);
        for (int f = 0; f < 8; f++)
            for (int v = 0; v < V; v++) begin
                kind = (f == 0 && v == 0) ? 0 : $urandom_range(7);
                fw   = $urandom_range(W - 1);
                x    = 32'h1 << $urandom_range(31);
                send_line((f0 + f) % 16, v, W,
                          (kind == 1) ? fw : -1, x,
                          (kind == 2) ? fw : -1,
                          (kind == 3 && fw < W - 1) ? fw : -1,
                          kind == 4, 1'b1);
            end
        idle(4);
        chk("random_error_count", 64'(error_count), 64'(m_cnt));
        chk("random_locked", 64'(locked), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
